tcam_pipelined_lookup: RTL and testbench

Pipelined ternary match engine with internal entry storage, per-entry valid bits, and a lowest-index priority encoder. Lookups enter through a valid/ready handshake and return an encoded result at fixed latency with a passthrough tag. Entries are written or invalidated through a single-cycle write port. Sits in the user data path between header parsing and action lookup, replacing the flat-vector matcher that needs external storage.

---
 rtl/tcam_pipelined_lookup.sv | 241 ++++++++++++++++++++++++
 tb/tb_tcam_pipelined_lookup.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_pipelined_lookup.sv
// Pipelined ternary match engine: internal entry storage, lowest-index priority encode, tag passthrough.
// Define TCAM_PIPE_STAGE_EN to split the encode into two half-depth stages (latency 3 instead of 2).
module tcam_pipelined_lookup #(
  parameter int CMP_WIDTH  = 32,
  parameter int DEPTH      = 32,
  parameter int DEPTH_BITS = 5,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lkup_valid,
  output logic                  lkup_ready,
  input  logic [CMP_WIDTH-1:0]  lkup_key,
  input  logic [TAG_WIDTH-1:0]  lkup_tag,
  output logic                  res_valid,
  output logic                  res_hit,
  output logic                  res_multi,
  output logic [DEPTH_BITS-1:0] res_addr,
  output logic [TAG_WIDTH-1:0]  res_tag,
  input  logic                  wr_en,
  input  logic [DEPTH_BITS-1:0] wr_addr,
  input  logic [CMP_WIDTH-1:0]  wr_data,
  input  logic [CMP_WIDTH-1:0]  wr_mask,
  input  logic                  wr_valid,
  output logic [DEPTH_BITS:0]   num_valid
);

  localparam int HALF = DEPTH / 2;

  logic [CMP_WIDTH-1:0]  data_q [DEPTH];
  logic [CMP_WIDTH-1:0]  data_d [DEPTH];
  logic [CMP_WIDTH-1:0]  mask_q [DEPTH];
  logic [CMP_WIDTH-1:0]  mask_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      wr_sel;
  logic [DEPTH-1:0]      match_vec;
  logic [DEPTH_BITS:0]   num_valid_q, num_valid_d;

  logic                  ready_pre_q, ready_pre_d;
  logic                  ready_q, ready_d;
  logic                  lkup_fire;

  logic                  c_valid_q, c_valid_d;
  logic [DEPTH-1:0]      c_match_q, c_match_d;
  logic [TAG_WIDTH-1:0]  c_tag_q, c_tag_d;

  logic                  e_valid;
  logic                  e_hit;
  logic                  e_multi;
  logic [DEPTH_BITS-1:0] e_addr;
  logic [TAG_WIDTH-1:0]  e_tag;

  logic                  res_valid_q, res_valid_d;
  logic                  res_hit_q, res_hit_d;
  logic                  res_multi_q, res_multi_d;
  logic [DEPTH_BITS-1:0] res_addr_q, res_addr_d;
  logic [TAG_WIDTH-1:0]  res_tag_q, res_tag_d;

  // Out-of-range write addresses select no entry, so they leave all state untouched.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign wr_sel[gi]    = wr_en && (wr_addr == DEPTH_BITS'(gi));
      assign match_vec[gi] = valid_q[gi] && (&((lkup_key ~^ data_q[gi]) | mask_q[gi]));
    end
  endgenerate

  always_comb begin
    valid_d     = valid_q;
    num_valid_d = num_valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
      mask_d[i] = mask_q[i];
      if (wr_sel[i]) begin
        valid_d[i] = wr_valid;
        if (wr_valid) begin
          data_d[i] = wr_data;
          mask_d[i] = wr_mask;
        end
      end
    end
    if (wr_valid && |(wr_sel & ~valid_q))
      num_valid_d = num_valid_q + (DEPTH_BITS+1)'(1);
    else if (!wr_valid && |(wr_sel & valid_q))
      num_valid_d = num_valid_q - (DEPTH_BITS+1)'(1);
  end

  // Two-flop ready: low through reset and the first cycle after it.
  always_comb begin
    ready_pre_d = 1'b1;
    ready_d     = ready_pre_q;
    lkup_fire   = lkup_valid && ready_q;
    c_valid_d   = lkup_fire;
    c_match_d   = lkup_fire ? match_vec : c_match_q;
    c_tag_d     = lkup_fire ? lkup_tag  : c_tag_q;
  end

`ifdef TCAM_PIPE_STAGE_EN
  logic                  lo_hit, lo_multi, hi_hit, hi_multi;
  logic [DEPTH_BITS-1:0] lo_addr, hi_addr;
  logic                  p_valid_q, p_valid_d;
  logic                  p_lo_hit_q, p_lo_hit_d, p_lo_multi_q, p_lo_multi_d;
  logic                  p_hi_hit_q, p_hi_hit_d, p_hi_multi_q, p_hi_multi_d;
  logic [DEPTH_BITS-1:0] p_lo_addr_q, p_lo_addr_d, p_hi_addr_q, p_hi_addr_d;
  logic [TAG_WIDTH-1:0]  p_tag_q, p_tag_d;

  always_comb begin
    lo_hit   = 1'b0;
    lo_multi = 1'b0;
    lo_addr  = '0;
    hi_hit   = 1'b0;
    hi_multi = 1'b0;
    hi_addr  = '0;
    for (int i = HALF - 1; i >= 0; i--) begin
      if (c_match_q[i]) begin
        lo_multi = lo_multi | lo_hit;
        lo_hit   = 1'b1;
        lo_addr  = DEPTH_BITS'(i);
      end
    end
    for (int i = DEPTH - 1; i >= HALF; i--) begin
      if (c_match_q[i]) begin
        hi_multi = hi_multi | hi_hit;
        hi_hit   = 1'b1;
        hi_addr  = DEPTH_BITS'(i);
      end
    end
  end

  always_comb begin
    p_valid_d    = c_valid_q;
    p_lo_hit_d   = c_valid_q ? lo_hit   : p_lo_hit_q;
    p_lo_multi_d = c_valid_q ? lo_multi : p_lo_multi_q;
    p_lo_addr_d  = c_valid_q ? lo_addr  : p_lo_addr_q;
    p_hi_hit_d   = c_valid_q ? hi_hit   : p_hi_hit_q;
    p_hi_multi_d = c_valid_q ? hi_multi : p_hi_multi_q;
    p_hi_addr_d  = c_valid_q ? hi_addr  : p_hi_addr_q;
    p_tag_d      = c_valid_q ? c_tag_q  : p_tag_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid_q    <= 1'b0;
      p_lo_hit_q   <= 1'b0;
      p_lo_multi_q <= 1'b0;
      p_lo_addr_q  <= '0;
      p_hi_hit_q   <= 1'b0;
      p_hi_multi_q <= 1'b0;
      p_hi_addr_q  <= '0;
      p_tag_q      <= '0;
    end else begin
      p_valid_q    <= p_valid_d;
      p_lo_hit_q   <= p_lo_hit_d;
      p_lo_multi_q <= p_lo_multi_d;
      p_lo_addr_q  <= p_lo_addr_d;
      p_hi_hit_q   <= p_hi_hit_d;
      p_hi_multi_q <= p_hi_multi_d;
      p_hi_addr_q  <= p_hi_addr_d;
      p_tag_q      <= p_tag_d;
    end
  end

  // Lower half wins the address; a hit in both halves is itself a multi-match.
  always_comb begin
    e_valid = p_valid_q;
    e_tag   = p_tag_q;
    e_hit   = p_lo_hit_q | p_hi_hit_q;
    e_multi = p_lo_multi_q | p_hi_multi_q | (p_lo_hit_q & p_hi_hit_q);
    e_addr  = p_lo_hit_q ? p_lo_addr_q : (p_hi_hit_q ? p_hi_addr_q : '0);
  end
`else
  always_comb begin
    e_valid = c_valid_q;
    e_tag   = c_tag_q;
    e_hit   = 1'b0;
    e_multi = 1'b0;
    e_addr  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (c_match_q[i]) begin
        e_multi = e_multi | e_hit;
        e_hit   = 1'b1;
        e_addr  = DEPTH_BITS'(i);
      end
    end
  end
`endif

  always_comb begin
    res_valid_d = e_valid;
    res_hit_d   = e_valid ? e_hit   : res_hit_q;
    res_multi_d = e_valid ? e_multi : res_multi_q;
    res_addr_d  = e_valid ? e_addr  : res_addr_q;
    res_tag_d   = e_valid ? e_tag   : res_tag_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
      valid_q     <= '0;
      num_valid_q <= '0;
      ready_pre_q <= 1'b0;
      ready_q     <= 1'b0;
      c_valid_q   <= 1'b0;
      c_match_q   <= '0;
      c_tag_q     <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_multi_q <= 1'b0;
      res_addr_q  <= '0;
      res_tag_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
        mask_q[i] <= mask_d[i];
      end
      valid_q     <= valid_d;
      num_valid_q <= num_valid_d;
      ready_pre_q <= ready_pre_d;
      ready_q     <= ready_d;
      c_valid_q   <= c_valid_d;
      c_match_q   <= c_match_d;
      c_tag_q     <= c_tag_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_multi_q <= res_multi_d;
      res_addr_q  <= res_addr_d;
      res_tag_q   <= res_tag_d;
    end
  end

  assign lkup_ready = ready_q;
  assign num_valid  = num_valid_q;
  assign res_valid  = res_valid_q;
  assign res_hit    = res_hit_q;
  assign res_multi  = res_multi_q;
  assign res_addr   = res_addr_q;
  assign res_tag    = res_tag_q;

endmodule

// File: tb/tb_tcam_pipelined_lookup.sv
// Directed bench for tcam_pipelined_lookup; DEPTH=24 so out-of-range write addresses exist.
module tb_tcam_pipelined_lookup;

  localparam int CW = 32;
  localparam int DEPTH = 24;
  localparam int DB = 5;
  localparam int TW = 8;
`ifdef TCAM_PIPE_STAGE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          lkup_valid;
  logic          lkup_ready;
  logic [CW-1:0] lkup_key;
  logic [TW-1:0] lkup_tag;
  logic          res_valid;
  logic          res_hit;
  logic          res_multi;
  logic [DB-1:0] res_addr;
  logic [TW-1:0] res_tag;
  logic          wr_en;
  logic [DB-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic [CW-1:0] wr_mask;
  logic          wr_valid;
  logic [DB:0]   num_valid;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [CW-1:0] key;
    logic [TW-1:0] tag;
    logic          hit;
    logic          multi;
    logic [DB-1:0] addr;
  } vec_t;

  vec_t vecs [9];

  tcam_pipelined_lookup #(.CMP_WIDTH(CW), .DEPTH(DEPTH), .DEPTH_BITS(DB), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .lkup_valid(lkup_valid), .lkup_ready(lkup_ready), .lkup_key(lkup_key), .lkup_tag(lkup_tag),
    .res_valid(res_valid), .res_hit(res_hit), .res_multi(res_multi), .res_addr(res_addr),
    .res_tag(res_tag),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_valid(wr_valid),
    .num_valid(num_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [DB-1:0] a, input logic [CW-1:0] d,
                          input logic [CW-1:0] m, input logic v);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m; wr_valid = v;
    tick();
    wr_en = 1'b0;
    $display("write addr=%0d data=0x%08h mask=0x%08h valid=%0b -> num_valid=%0d", a, d, m, v, num_valid);
  endtask

  task automatic do_lookup(input vec_t v, input string name);
    chk({name, ".ready"}, 32'(lkup_ready), 32'd1);
    lkup_valid = 1'b1; lkup_key = v.key; lkup_tag = v.tag;
    tick();
    lkup_valid = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      chk({name, ".early_valid"}, 32'(res_valid), 32'd0);
      tick();
    end
    chk({name, ".valid"}, 32'(res_valid), 32'd1);
    chk({name, ".hit"},   32'(res_hit),   32'(v.hit));
    chk({name, ".multi"}, 32'(res_multi), 32'(v.multi));
    chk({name, ".addr"},  32'(res_addr),  32'(v.addr));
    chk({name, ".tag"},   32'(res_tag),   32'(v.tag));
    $display("lookup %s key=0x%08h tag=0x%02h -> hit=%0b multi=%0b addr=%0d tag=0x%02h",
             name, v.key, v.tag, res_hit, res_multi, res_addr, res_tag);
    tick();
    chk({name, ".pulse"}, 32'(res_valid), 32'd0);
    chk({name, ".held_tag"}, 32'(res_tag), 32'(v.tag));
  endtask

  initial begin
    vec_t v;
    int   pulses;
    vecs[0] = '{32'h0A000001, 8'h21, 1'b1, 1'b1, 5'd3};
    vecs[1] = '{32'h0A000102, 8'h22, 1'b0, 1'b0, 5'd0};
    vecs[2] = '{32'h0A0000FF, 8'h23, 1'b1, 1'b0, 5'd3};
    vecs[3] = '{32'h0A000100, 8'h24, 1'b0, 1'b0, 5'd0};
    vecs[4] = '{32'hDEADBEEF, 8'h31, 1'b1, 1'b0, 5'd23};
    vecs[5] = '{32'h0B000005, 8'h32, 1'b1, 1'b1, 5'd12};
    vecs[6] = '{32'h0A000001, 8'h33, 1'b1, 1'b1, 5'd7};
    vecs[7] = '{32'h0B00FFFF, 8'h34, 1'b1, 1'b1, 5'd20};
    vecs[8] = '{32'h0A000000, 8'h35, 1'b1, 1'b0, 5'd23};

    reset = 1'b1; lkup_valid = 1'b0; lkup_key = '0; lkup_tag = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0; wr_valid = 1'b0;
    repeat (3) tick();
    chk("rst.ready", 32'(lkup_ready), 32'd0);
    chk("rst.valid", 32'(res_valid), 32'd0);
    chk("rst.hit", 32'(res_hit), 32'd0);
    chk("rst.multi", 32'(res_multi), 32'd0);
    chk("rst.addr", 32'(res_addr), 32'd0);
    chk("rst.tag", 32'(res_tag), 32'd0);
    chk("rst.num_valid", 32'(num_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst.ready_first_cycle", 32'(lkup_ready), 32'd0);
    tick();
    chk("rst.ready_second_cycle", 32'(lkup_ready), 32'd1);

    v = '{32'h0A000001, 8'h11, 1'b0, 1'b0, 5'd0};
    do_lookup(v, "empty");
    chk("empty.num_valid", 32'(num_valid), 32'd0);

    do_write(5'd3, 32'h0A000000, 32'h000000FF, 1'b1);
    do_write(5'd7, 32'h0A000001, 32'h00000000, 1'b1);
    chk("install.num_valid", 32'(num_valid), 32'd2);
    for (int i = 0; i < 4; i++) do_lookup(vecs[i], $sformatf("tbl%0d", i));

    // Invalidate entry 3 in the same cycle as a lookup, then look up again next cycle.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = '0; wr_mask = '0; wr_valid = 1'b0;
    lkup_valid = 1'b1; lkup_key = 32'h0A000001; lkup_tag = 8'h41;
    tick();
    wr_en = 1'b0; lkup_tag = 8'h42;
    tick();
    lkup_valid = 1'b0;
    repeat (LAT - 2) tick();
    chk("samecyc.valid", 32'(res_valid), 32'd1);
    chk("samecyc.addr", 32'(res_addr), 32'd3);
    chk("samecyc.multi", 32'(res_multi), 32'd1);
    chk("samecyc.tag", 32'(res_tag), 32'h41);
    $display("lookup samecyc tag=0x%02h -> hit=%0b multi=%0b addr=%0d", res_tag, res_hit, res_multi, res_addr);
    tick();
    chk("nextcyc.valid", 32'(res_valid), 32'd1);
    chk("nextcyc.hit", 32'(res_hit), 32'd1);
    chk("nextcyc.addr", 32'(res_addr), 32'd7);
    chk("nextcyc.multi", 32'(res_multi), 32'd0);
    chk("nextcyc.tag", 32'(res_tag), 32'h42);
    $display("lookup nextcyc tag=0x%02h -> hit=%0b multi=%0b addr=%0d", res_tag, res_hit, res_multi, res_addr);
    tick();
    chk("inval.num_valid", 32'(num_valid), 32'd1);

    do_write(5'd7, 32'h0A000001, 32'h00000000, 1'b1);
    chk("overwrite.num_valid", 32'(num_valid), 32'd1);
    do_write(5'd5, 32'h12345678, 32'h00000000, 1'b0);
    chk("inval_invalid.num_valid", 32'(num_valid), 32'd1);
    do_write(5'd25, 32'h00000000, 32'hFFFFFFFF, 1'b1);
    chk("oor.num_valid", 32'(num_valid), 32'd1);
    v = '{32'hDEADBEEF, 8'h51, 1'b0, 1'b0, 5'd0};
    do_lookup(v, "oor");

    // 64 back-to-back lookups: even tags hit entry 7, odd tags miss.
    pulses = 0;
    for (int c = 0; c < 64 + LAT; c++) begin
      if (c < 64) begin
        lkup_valid = 1'b1;
        lkup_tag   = 8'(c);
        lkup_key   = (c % 2 == 0) ? 32'h0A000001 : 32'h00000000;
      end else begin
        lkup_valid = 1'b0;
      end
      if (res_valid) pulses++;
      if (c >= LAT) begin
        int r;
        r = c - LAT;
        chk($sformatf("b2b%0d.valid", r), 32'(res_valid), 32'd1);
        chk($sformatf("b2b%0d.tag", r), 32'(res_tag), 32'(r));
        chk($sformatf("b2b%0d.hit", r), 32'(res_hit), (r % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("b2b%0d.addr", r), 32'(res_addr), (r % 2 == 0) ? 32'd7 : 32'd0);
        $display("lookup b2b%0d tag=0x%02h -> hit=%0b addr=%0d", r, res_tag, res_hit, res_addr);
      end else begin
        chk($sformatf("b2b.pre%0d", c), 32'(res_valid), 32'd0);
      end
      tick();
    end
    chk("b2b.tail", 32'(res_valid), 32'd0);
    chk("b2b.pulses", 32'(pulses), 32'd64);

    do_write(5'd20, 32'h0B000000, 32'h0000FFFF, 1'b1);
    do_write(5'd12, 32'h0B000005, 32'h00000000, 1'b1);
    do_write(5'd23, 32'h00000000, 32'hFFFFFFFF, 1'b1);
    chk("upper.num_valid", 32'(num_valid), 32'd4);
    for (int i = 4; i < 9; i++) do_lookup(vecs[i], $sformatf("tbl%0d", i));

    // Reset with two lookups in flight: neither may ever produce a result.
    lkup_valid = 1'b1; lkup_key = 32'h0A000001; lkup_tag = 8'h61;
    tick();
    lkup_tag = 8'h62; reset = 1'b1;
    tick();
    lkup_valid = 1'b0;
    chk("midrst.ready", 32'(lkup_ready), 32'd0);
    chk("midrst.valid0", 32'(res_valid), 32'd0);
    tick();
    chk("midrst.valid1", 32'(res_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("midrst.valid2", 32'(res_valid), 32'd0);
    chk("midrst.ready_first_cycle", 32'(lkup_ready), 32'd0);
    tick();
    chk("midrst.valid3", 32'(res_valid), 32'd0);
    chk("midrst.ready_second_cycle", 32'(lkup_ready), 32'd1);
    chk("midrst.tag", 32'(res_tag), 32'd0);
    chk("midrst.num_valid", 32'(num_valid), 32'd0);
    $display("reset mid-pipeline done, num_valid=%0d", num_valid);
    v = '{32'h0A000001, 8'h71, 1'b0, 1'b0, 5'd0};
    do_lookup(v, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
